hpi_responder: RTL and testbench

- Target-side end of the 4-register host port interface (HPI) that the SoC drives through its hpi_addr/cs/r/w/data PIOs.
- Decodes host DATA / MAILBOX / ADDRESS / STATUS accesses and owns a word-addressed shared RAM.
- Provides a bidirectional mailbox to a local agent, with an interrupt line back to the host.
- Used as the on-chip peer for loopback bring-up and as a synthesizable stand-in for the USB controller.

---
 rtl/hpi_pkg.sv | 20 ++
 rtl/hpi_dpram.sv | 38 +++
 rtl/hpi_responder.sv | 189 ++++++++++++++++++
 tb/tb_hpi_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI responder: register selects, STATUS bit
// positions and the host access tracking states.
package hpi_pkg;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int ST_OUT_FULL = 0;
    localparam int ST_IN_FULL  = 1;
    localparam int ST_ERROR    = 2;
    localparam int ST_OVERRUN  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } acc_state_e;

endpackage

// File: rtl/hpi_dpram.sv
// Simple dual-port RAM: port A read/write for the host, port B read-only for the
// local agent. Both reads are registered; B returns old data on a same-address write.
module hpi_dpram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_we_i,
    input  logic          a_re_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [15:0]   a_wdata_i,
    output logic [15:0]   a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [15:0]   b_rdata_o
);

    logic [15:0] mem_q [DEPTH];

    // Port A output only moves on a read so a host read word holds for the access.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (a_re_i) begin
            a_rdata_o <= mem_q[a_addr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_rdata_o <= '0;
        end else begin
            b_rdata_o <= mem_q[b_addr_i];
        end
    end

endmodule

// File: rtl/hpi_responder.sv
// Target side of the 4-register host port interface: register decode, shared RAM
// and a bidirectional mailbox to a local agent.
//
// state  | meaning
// IDLE   | no strobe seen last cycle; a legal strobe now starts an access
// ACTIVE | access or illegal strobe in progress; wait for it to end
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          hpi_reset_n,
    input  logic [1:0]    hpi_addr,
    input  logic          hpi_cs_n,
    input  logic          hpi_r_n,
    input  logic          hpi_w_n,
    input  logic [15:0]   hpi_data_in,
    output logic [15:0]   hpi_data_out,
    output logic          hpi_data_oe,
    output logic          hpi_int,
    output logic [15:0]   mbx_in_data,
    output logic          mbx_in_valid,
    input  logic          mbx_in_ack,
    input  logic [15:0]   mbx_out_data,
    input  logic          mbx_out_wr,
    input  logic [AW-1:0] lcl_addr,
    output logic [15:0]   lcl_rdata
);

    acc_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] in_data_q, in_data_d;
    logic        in_full_q, in_full_d;
    logic [15:0] out_word_q, out_word_d;
    logic        out_full_q, out_full_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic [15:0] dout_q, dout_d;
    logic        src_ram_q, src_ram_d;
    logic        oe_q, oe_d;

    logic        rd_req, wr_req, ill_req, start;
    logic        in_range, ram_we, ram_re;
    logic [15:0] ram_rdata, status;

    assign rd_req   = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
    assign wr_req   = !hpi_cs_n &&  hpi_r_n && !hpi_w_n;
    assign ill_req  = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
    assign start    = (state_q == IDLE) && (rd_req || wr_req) && hpi_reset_n;
    assign in_range = ({1'b0, addr_q[15:1]} < 16'(DEPTH));
    assign status   = {12'b0, ovr_q, err_q, in_full_q, out_full_q};

    always_comb begin
        state_d    = (rd_req || wr_req || ill_req) ? ACTIVE : IDLE;
        addr_d     = addr_q;
        in_data_d  = in_data_q;
        in_full_d  = in_full_q;
        out_word_d = out_word_q;
        out_full_d = out_full_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        dout_d     = dout_q;
        src_ram_d  = src_ram_q;
        oe_d       = oe_q && rd_req;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (mbx_in_ack) begin
            in_full_d = 1'b0;
        end
        if (mbx_out_wr) begin
            out_word_d = mbx_out_data;
            out_full_d = 1'b1;
        end
        if (ill_req) begin
            err_d = 1'b1;
        end

        if (start && rd_req) begin
            oe_d      = 1'b1;
            src_ram_d = 1'b0;
            dout_d    = '0;
            case (hpi_addr)
                HPI_DATA: begin
                    ram_re    = in_range;
                    src_ram_d = in_range;
                    err_d     = err_d || !in_range;
                    addr_d    = addr_q + 16'd2;
                end
                HPI_MAILBOX: begin
                    dout_d = out_word_q;
                    // A local load in the same cycle keeps the flag for the new word.
                    if (!mbx_out_wr) begin
                        out_full_d = 1'b0;
                    end
                end
                HPI_ADDRESS: dout_d = addr_q;
                default:     dout_d = status;
            endcase
        end

        if (start && wr_req) begin
            case (hpi_addr)
                HPI_DATA: begin
                    ram_we = in_range;
                    err_d  = err_d || !in_range;
                    addr_d = addr_q + 16'd2;
                end
                HPI_MAILBOX: begin
                    in_data_d = hpi_data_in;
                    in_full_d = 1'b1;
                    // An ack in the same cycle consumed the old word, so no overrun.
                    if (in_full_q && !mbx_in_ack) begin
                        ovr_d = 1'b1;
                    end
                end
                HPI_ADDRESS: addr_d = hpi_data_in;
                default: begin
                    if (hpi_data_in[ST_OVERRUN]) ovr_d = 1'b0;
                    if (hpi_data_in[ST_ERROR])   err_d = 1'b0;
                end
            endcase
        end

        if (!hpi_reset_n) begin
            addr_d     = '0;
            in_full_d  = 1'b0;
            out_full_d = 1'b0;
            err_d      = 1'b0;
            ovr_d      = 1'b0;
            dout_d     = '0;
            src_ram_d  = 1'b0;
            oe_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            in_data_q  <= '0;
            in_full_q  <= 1'b0;
            out_word_q <= '0;
            out_full_q <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            dout_q     <= '0;
            src_ram_q  <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            in_data_q  <= in_data_d;
            in_full_q  <= in_full_d;
            out_word_q <= out_word_d;
            out_full_q <= out_full_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            dout_q     <= dout_d;
            src_ram_q  <= src_ram_d;
            oe_q       <= oe_d;
        end
    end

    hpi_dpram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk_i    (clk_clk),
        .rst_i    (reset_reset),
        .a_we_i   (ram_we),
        .a_re_i   (ram_re),
        .a_addr_i (addr_q[AW:1]),
        .a_wdata_i(hpi_data_in),
        .a_rdata_o(ram_rdata),
        .b_addr_i (lcl_addr),
        .b_rdata_o(lcl_rdata)
    );

    assign hpi_data_out = src_ram_q ? ram_rdata : dout_q;
    assign hpi_data_oe  = oe_q;
    assign hpi_int      = out_full_q;
    assign mbx_in_data  = in_data_q;
    assign mbx_in_valid = in_full_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed plus randomized bench for hpi_responder, checked every cycle against
// a transaction-level model of the register, mailbox and RAM behaviour.
module tb_hpi_responder;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk_clk = 1'b0;
    logic          reset_reset, hpi_reset_n;
    logic [1:0]    hpi_addr;
    logic          hpi_cs_n, hpi_r_n, hpi_w_n;
    logic [15:0]   hpi_data_in, hpi_data_out;
    logic          hpi_data_oe, hpi_int;
    logic [15:0]   mbx_in_data;
    logic          mbx_in_valid, mbx_in_ack;
    logic [15:0]   mbx_out_data;
    logic          mbx_out_wr;
    logic [AW-1:0] lcl_addr;
    logic [15:0]   lcl_rdata;

    hpi_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .hpi_reset_n (hpi_reset_n),
        .hpi_addr    (hpi_addr),
        .hpi_cs_n    (hpi_cs_n),
        .hpi_r_n     (hpi_r_n),
        .hpi_w_n     (hpi_w_n),
        .hpi_data_in (hpi_data_in),
        .hpi_data_out(hpi_data_out),
        .hpi_data_oe (hpi_data_oe),
        .hpi_int     (hpi_int),
        .mbx_in_data (mbx_in_data),
        .mbx_in_valid(mbx_in_valid),
        .mbx_in_ack  (mbx_in_ack),
        .mbx_out_data(mbx_out_data),
        .mbx_out_wr  (mbx_out_wr),
        .lcl_addr    (lcl_addr),
        .lcl_rdata   (lcl_rdata)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rnd_local = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_addr;
    bit          m_in_full, m_out_full, m_err, m_ovr, m_prev_acc;
    logic [15:0] m_in_data, m_out_word;
    logic [15:0] m_ram [DEPTH];
    bit          m_known [DEPTH];
    bit          e_oe, e_dout_known, e_lcl_known;
    logic [15:0] e_dout, e_lcl;

    function automatic logic [15:0] m_status();
        return {12'b0, m_ovr, m_err, m_in_full, m_out_full};
    endfunction

    function automatic void model_reset();
        m_addr = 0; m_in_full = 0; m_out_full = 0; m_err = 0; m_ovr = 0;
        m_prev_acc = 0; m_in_data = '0; m_out_word = '0;
        e_oe = 0; e_dout = '0; e_dout_known = 1; e_lcl = '0; e_lcl_known = 1;
    endfunction

    function automatic void model_step();
        bit rd, wr, ill, start, inr, full_before;
        int widx;
        logic [15:0] st, old_word;
        rd  = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
        wr  = !hpi_cs_n &&  hpi_r_n && !hpi_w_n;
        ill = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
        start = (rd || wr) && !m_prev_acc;
        m_prev_acc = rd || wr || ill;
        e_lcl_known = m_known[lcl_addr];
        e_lcl = m_ram[lcl_addr];
        if (!hpi_reset_n) begin
            if (mbx_out_wr) m_out_word = mbx_out_data;
            m_addr = 0; m_in_full = 0; m_out_full = 0; m_err = 0; m_ovr = 0;
            e_dout = '0; e_dout_known = 1; e_oe = 0;
            return;
        end
        st = m_status();
        full_before = m_in_full;
        old_word = m_out_word;
        widx = m_addr / 2;
        inr = widx < DEPTH;
        e_oe = (e_oe && rd) || (start && rd);
        if (mbx_in_ack) m_in_full = 0;
        if (mbx_out_wr) begin m_out_word = mbx_out_data; m_out_full = 1; end
        if (ill) m_err = 1;
        if (start && rd) begin
            e_dout_known = 1;
            case (hpi_addr)
                2'd0: begin
                    if (inr) begin e_dout = m_ram[widx]; e_dout_known = m_known[widx]; end
                    else begin e_dout = '0; m_err = 1; end
                    m_addr = (m_addr + 2) % 65536;
                end
                2'd1: begin e_dout = old_word; if (!mbx_out_wr) m_out_full = 0; end
                2'd2: e_dout = 16'(m_addr);
                default: e_dout = st;
            endcase
        end
        if (start && wr) begin
            case (hpi_addr)
                2'd0: begin
                    if (inr) begin m_ram[widx] = hpi_data_in; m_known[widx] = 1; end
                    else m_err = 1;
                    m_addr = (m_addr + 2) % 65536;
                end
                2'd1: begin
                    m_in_data = hpi_data_in;
                    if (full_before && !mbx_in_ack) m_ovr = 1;
                    m_in_full = 1;
                end
                2'd2: m_addr = int'(hpi_data_in);
                default: begin
                    if (hpi_data_in[3]) m_ovr = 0;
                    if (hpi_data_in[2]) m_err = 0;
                end
            endcase
        end
    endfunction

    always @(posedge clk_clk) begin
        if (reset_reset) model_reset();
        else model_step();
    end

    always @(negedge clk_clk) begin
        if (chk_en) begin
            check("cyc_oe", 16'(hpi_data_oe), 16'(e_oe));
            check("cyc_int", 16'(hpi_int), 16'(m_out_full));
            check("cyc_in_valid", 16'(mbx_in_valid), 16'(m_in_full));
            check("cyc_in_data", mbx_in_data, m_in_data);
            if (e_dout_known) check("cyc_data_out", hpi_data_out, e_dout);
            if (e_lcl_known) check("cyc_lcl_rdata", lcl_rdata, e_lcl);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk_clk);
        if (rnd_local) begin
            mbx_in_ack   = ($urandom_range(0, 5) == 0);
            mbx_out_wr   = ($urandom_range(0, 5) == 0);
            mbx_out_data = 16'($urandom);
            lcl_addr     = AW'($urandom_range(0, 40));
        end
    endtask

    task automatic host(input logic [1:0] a, input bit rd, input bit wr, input logic [15:0] d,
                        input int hold, output logic [15:0] rdv);
        hpi_addr = a; hpi_data_in = d;
        hpi_cs_n = 1'b0; hpi_r_n = !rd; hpi_w_n = !wr;
        rdv = '0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (i == 0) rdv = hpi_data_out;
        end
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        step();
    endtask

    task automatic hw(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        host(a, 1'b0, 1'b1, d, 1, dummy);
    endtask

    task automatic hr(input logic [1:0] a, output logic [15:0] v);
        host(a, 1'b1, 1'b0, 16'h0, 1, v);
    endtask

    function automatic logic [15:0] pick_addr();
        int k;
        logic [15:0] a;
        k = $urandom_range(0, 7);
        if (k < 6)       a = 16'(2 * $urandom_range(0, 31));
        else if (k == 6) a = 16'(32'h07FC + 2 * $urandom_range(0, 3));
        else             a = 16'(32'hFFFC + 2 * $urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
        return a;
    endfunction

    logic [15:0] v, first;

    initial begin
        reset_reset = 1'b1; hpi_reset_n = 1'b1;
        hpi_addr = 2'd0; hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1; hpi_data_in = '0;
        mbx_in_ack = 1'b0; mbx_out_data = '0; mbx_out_wr = 1'b0; lcl_addr = '0;
        model_reset();
        repeat (3) step();
        reset_reset = 1'b0;
        chk_en = 1'b1;

        check("rst_oe", 16'(hpi_data_oe), 16'h0);
        check("rst_int", 16'(hpi_int), 16'h0);
        check("rst_lcl", lcl_rdata, 16'h0);
        check("rst_dout", hpi_data_out, 16'h0);
        hr(2'd3, v); check("rst_status", v, 16'h0000);
        hr(2'd2, v); check("rst_address", v, 16'h0000);

        // RAM write/read through DATA with auto-increment
        hw(2'd2, 16'h0010); hw(2'd0, 16'hAAAA); hw(2'd0, 16'h5555);
        hw(2'd2, 16'h0010);
        hr(2'd0, v); check("ram_rd0", v, 16'hAAAA);
        hr(2'd0, v); check("ram_rd1", v, 16'h5555);
        hr(2'd2, v); check("addr_after", v, 16'h0014);
        lcl_addr = AW'(8); step();
        check("lcl_rd", lcl_rdata, 16'hAAAA);

        // outbound mailbox
        mbx_out_data = 16'h1234; mbx_out_wr = 1'b1; step(); mbx_out_wr = 1'b0;
        check("int_set", 16'(hpi_int), 16'h1);
        hr(2'd3, v); check("st_out_full", v, 16'h0001);
        hr(2'd1, v); check("mbx_out_rd", v, 16'h1234);
        check("int_clr", 16'(hpi_int), 16'h0);
        hr(2'd3, v); check("st_empty", v, 16'h0000);

        // inbound mailbox overrun and W1C
        hw(2'd1, 16'h0001); hw(2'd1, 16'h0002);
        check("mbx_in_data", mbx_in_data, 16'h0002);
        hr(2'd3, v); check("st_overrun", v, 16'h000A);
        hw(2'd3, 16'h000C);
        hr(2'd3, v); check("st_w1c", v, 16'h0002);
        mbx_in_ack = 1'b1; step(); mbx_in_ack = 1'b0;
        hr(2'd3, v); check("st_acked", v, 16'h0000);

        // long read strobe: one action only
        hw(2'd2, 16'h0010);
        hpi_addr = 2'd0; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin first = hpi_data_out; check("hold_first", first, 16'hAAAA); end
            check("hold_stable", hpi_data_out, first);
            check("hold_oe", 16'(hpi_data_oe), 16'h1);
        end
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; step();
        hr(2'd2, v); check("hold_addr", v, 16'h0012);

        // out-of-range and wrap, illegal strobes, last valid word
        hw(2'd2, 16'hFFFE); hw(2'd0, 16'hBEEF);
        hr(2'd3, v); check("oor_err", v, 16'h0004);
        hr(2'd2, v); check("wrap_addr", v, 16'h0000);
        hw(2'd3, 16'h0004);
        hr(2'd3, v); check("err_clr", v, 16'h0000);
        hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0; step();
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1; step();
        hr(2'd3, v); check("ill_err", v, 16'h0004);
        hw(2'd3, 16'h0004);
        hw(2'd2, 16'h0800);
        hr(2'd0, v); check("oor_rd", v, 16'h0000);
        hr(2'd2, v); check("oor_addr", v, 16'h0802);
        hw(2'd3, 16'h0004);
        hw(2'd2, 16'h07FE); hw(2'd0, 16'h7777); hw(2'd2, 16'h07FE);
        hr(2'd0, v); check("last_word", v, 16'h7777);
        hr(2'd3, v); check("last_word_st", v, 16'h0000);

        // async reset mid-read, RAM retained, soft reset
        mbx_out_data = 16'h00FF; mbx_out_wr = 1'b1; step(); mbx_out_wr = 1'b0;
        hw(2'd2, 16'h0010);
        hpi_addr = 2'd0; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b1;
        step();
        check("mid_oe", 16'(hpi_data_oe), 16'h1);
        #1 reset_reset = 1'b1; model_reset();
        #1 check("arst_oe", 16'(hpi_data_oe), 16'h0);
        check("arst_int", 16'(hpi_int), 16'h0);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
        step(); reset_reset = 1'b0; step();
        hw(2'd2, 16'h0010);
        hr(2'd0, v); check("ram_kept", v, 16'hAAAA);
        hw(2'd2, 16'h0020);
        hpi_reset_n = 1'b0; step(); hpi_reset_n = 1'b1;
        hr(2'd2, v); check("soft_rst_addr", v, 16'h0000);

        // randomized traffic against the model
        rnd_local = 1'b1;
        for (int t = 0; t < 1500; t++) begin
            int op, hold;
            logic [1:0] a;
            logic [15:0] d;
            op = $urandom_range(0, 9);
            a = 2'($urandom_range(0, 3));
            d = 16'($urandom);
            hold = $urandom_range(1, 3);
            if (a == 2'd2) d = pick_addr();
            if (op == 9) begin
                hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
                repeat (hold) step();
                hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
                step();
            end else begin
                host(a, op >= 4, op < 4, d, hold, v);
            end
            if ($urandom_range(0, 99) == 0) begin
                hpi_reset_n = 1'b0; step(); hpi_reset_n = 1'b1;
            end
        end
        rnd_local = 1'b0;
        mbx_in_ack = 1'b0; mbx_out_wr = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
